// File: rtl/matrix_pkg.sv
// Shared definitions for blocks that exchange the N x N result matrix over the ALU's parallel bus.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   N, W        default matrix dimension and element width
//   MAT_BITS    width of the flattened matrix bus, element (r,c) at [W*(r*N+c) +: W]
//   IDX_W       width of a flat element index
//   IDLE/SEND/TRAIL  serializer FSM encodings
//   frame_t     matrix plus overflow flag, as captured from the ALU
//   elem()      element select from a flattened matrix
package matrix_pkg;

  localparam int N        = 5;
  localparam int W        = 8;
  localparam int MAT_BITS = N * N * W;
  localparam int IDX_W    = $clog2(N * N);

  // FSM encodings kept as plain constants so older blocks can compare raw state bits.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] TRAIL = 2'd2;

  typedef struct packed {
    logic                ovf;
    logic [MAT_BITS-1:0] mat;
  } frame_t;

  // Row-major flat layout: element (r,c) lives at bit offset W*(r*N+c).
  function automatic logic [W-1:0] elem(input logic [MAT_BITS-1:0] mat,
                                        input int                  r,
                                        input int                  c);
    return mat[W*(r*N+c) +: W];
  endfunction

endpackage

// File: rtl/order_counter.sv
// Row/column walk over an N x N matrix producing the flat element index in send order.
// Latency: flat/wrap are combinational from the counter registers; they advance one step per inc.
// Backpressure: holds its position whenever inc is low, so the caller stalls it simply by not incrementing.
//
// Ports:
//   clk    in   clock, all state on posedge
//   rst    in   synchronous active-high reset, returns to element (0,0)
//   clear  in   synchronous return to element (0,0)
//   inc    in   advance to the next element; from the last element it returns to (0,0)
//   flat   out  r*N+c of the current element
//   wrap   out  current element is the last one in send order
module order_counter #(
  parameter int N         = 5,
  parameter bit COL_MAJOR = 1'b0,
  parameter int IDX_W     = $clog2(N * N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] flat,
  output logic             wrap
);

  localparam int              RC_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N * N - 1);

  logic [RC_W-1:0]  row;
  logic [RC_W-1:0]  col;
  // Sequence position in send order; only used to detect the final element.
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
      idx <= '0;
    end else if (inc) begin
      if (wrap) begin
        // No wrap past the last element: the walk restarts from (0,0).
        row <= '0;
        col <= '0;
        idx <= '0;
      end else begin
        idx <= idx + 1'b1;
        if (COL_MAJOR) begin
          // Rows are the inner loop.
          if (row == RC_MAX) begin
            row <= '0;
            col <= col + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          // Columns are the inner loop.
          if (col == RC_MAX) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

  // Constant multiply by N; the column-major order never needs a divide.
  assign flat = IDX_W'(row) * IDX_W'(N) + IDX_W'(col);
  assign wrap = (idx == IDX_MAX);

endmodule

// File: rtl/matrix_serializer.sv
// Captures one N x N result matrix plus overflow flag and streams it out one element per transfer.
// Latency: first byte valid the cycle after start; N*N+TRAILER cycles per frame with ready held high.
// Backpressure: valid/ready; while valid && !ready the byte, last and position all hold.
//
// Ports:
//   clk          in   clock, all state on posedge
//   rst          in   synchronous active-high reset; aborts a frame in flight without a done pulse
//   start        in   capture request, accepted only while idle
//   mat_in       in   N*N*W matrix, element (r,c) at [W*(r*N+c) +: W]
//   overflow_in  in   overflow flag captured together with mat_in
//   data_out     out  current element, or trailer byte {0..0, overflow}
//   data_valid   out  data_out holds a byte to transfer
//   data_ready   in   sink accepts the byte when data_valid && data_ready
//   last         out  marks the final byte of the frame
//   busy         out  frame in flight
//   done         out  one-cycle pulse in the first idle cycle after the final transfer
module matrix_serializer #(
  parameter int N         = 5,
  parameter int W         = 8,
  parameter bit COL_MAJOR = 1'b0,
  parameter bit TRAILER   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*N*W-1:0] mat_in,
  input  logic             overflow_in,
  output logic [W-1:0]     data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             last,
  output logic             busy,
  output logic             done
);

  import matrix_pkg::*;

  localparam int MB  = N * N * W;
  localparam int IXW = $clog2(N * N);

  logic [1:0]     state;
  logic [MB-1:0]  shadow_mat;
  logic           shadow_ovf;
  logic           done_r;

  logic           xfer;
  logic           cnt_inc;
  logic           cnt_clear;
  logic [IXW-1:0] flat;
  logic           wrap;

  assign xfer = data_valid && data_ready;

  // The counter advances only on an accepted element; stepping off the last
  // element returns it to zero, so it is already parked for the next frame.
  assign cnt_inc   = (state == SEND) && xfer;
  assign cnt_clear = (state == IDLE);

  order_counter #(
    .N         (N),
    .COL_MAJOR (COL_MAJOR),
    .IDX_W     (IXW)
  ) u_order (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .flat  (flat),
    .wrap  (wrap)
  );

  // Outputs are decoded from registered state and shadow data only, so they
  // are stable across a stall by construction.
  always_comb begin
    data_out   = '0;
    data_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state)
      SEND: begin
        data_valid = 1'b1;
        busy       = 1'b1;
        data_out   = shadow_mat[W*flat +: W];
        last       = wrap && !TRAILER;
      end
      TRAIL: begin
        data_valid = 1'b1;
        busy       = 1'b1;
        data_out   = {{(W-1){1'b0}}, shadow_ovf};
        last       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow_mat <= '0;
      shadow_ovf <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // Also covers the done cycle, which gives back-to-back frames.
          if (start) begin
            shadow_mat <= mat_in;
            shadow_ovf <= overflow_in;
            state      <= SEND;
          end
        end
        SEND: begin
          if (xfer && wrap) begin
            if (TRAILER) begin
              state <= TRAIL;
            end else begin
              state  <= IDLE;
              done_r <= 1'b1;
            end
          end
        end
        TRAIL: begin
          if (xfer) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = done_r;

endmodule
